// File: rtl/trojan_resp_checker.sv
`default_nettype none
// ============================================================================
// Module   : trojan_resp_checker
// Brief    : On-chip golden-response checker; compares streamed (vector,
//            response) pairs against a loaded truth table and reports
//            mismatch count, first failing vector and vector coverage.
//            Optional MISR signature output enabled by TROJAN_RESP_MISR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module trojan_resp_checker #(
  parameter int VEC_W = 8,
  parameter int CNT_W = VEC_W + 1
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [VEC_W-1:0] ld_addr,
  input  logic             ld_bit,
  input  logic             start,
  input  logic             abort,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [VEC_W-1:0] s_vec,
  input  logic             s_resp,
  output logic             busy,
  output logic             done,
  output logic             covered,
  output logic [CNT_W-1:0] mm_cnt,
  output logic [CNT_W-1:0] acc_cnt,
  output logic             first_mm_valid,
  output logic [VEC_W-1:0] first_mm_vec
`ifdef TROJAN_RESP_MISR_EN
  ,
  output logic [15:0]      sig
`endif
);

  localparam int               c_depth   = 2**VEC_W;
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_depth-1:0]   r_golden;
  logic [c_depth-1:0]   r_seen;
  logic [c_depth-1:0]   w_vec_onehot;
  logic [c_depth-1:0]   w_seen_nxt;
  logic [CNT_W-1:0]     r_mm_cnt;
  logic [CNT_W-1:0]     r_acc_cnt;
  logic                 r_first_mm_valid;
  logic [VEC_W-1:0]     r_first_mm_vec;
  logic                 w_accept;
  logic                 w_mismatch;
  logic                 w_ld_we;

  assign w_accept     = s_valid && (r_state == ST_CHECK);
  assign w_ld_we      = ld_valid && (r_state == ST_IDLE);
  assign w_mismatch   = (s_resp != r_golden[s_vec]);
  assign w_vec_onehot = {{(c_depth-1){1'b0}}, 1'b1} << s_vec;
  assign w_seen_nxt   = r_seen | w_vec_onehot;

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // start has priority over abort, completion and the DONE->IDLE exit
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (start)
          w_state_nxt = ST_CHECK;
        else if (abort || (w_accept && (&w_seen_nxt)))
          w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start)
          w_state_nxt = ST_CHECK;
        else if (ld_valid)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      r_golden <= '0;
    end else if (w_ld_we) begin
      r_golden[ld_addr] <= ld_bit;
    end
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      r_seen           <= '0;
      r_mm_cnt         <= '0;
      r_acc_cnt        <= '0;
      r_first_mm_valid <= 1'b0;
      r_first_mm_vec   <= '0;
    end else if (start) begin
      r_seen           <= '0;
      r_mm_cnt         <= '0;
      r_acc_cnt        <= '0;
      r_first_mm_valid <= 1'b0;
      r_first_mm_vec   <= '0;
    end else if (w_accept) begin
      r_seen <= w_seen_nxt;
      if (r_acc_cnt != c_cnt_max) r_acc_cnt <= r_acc_cnt + CNT_W'(1);
      if (w_mismatch) begin
        if (r_mm_cnt != c_cnt_max) r_mm_cnt <= r_mm_cnt + CNT_W'(1);
        if (!r_first_mm_valid) begin
          r_first_mm_valid <= 1'b1;
          r_first_mm_vec   <= s_vec;
        end
      end
    end
  end

`ifdef TROJAN_RESP_MISR_EN
  logic [15:0] r_sig;
  logic [15:0] w_sig_shift;

  // Galois form of x^16+x^12+x^5+1; accepts only occur in CHECK so DONE freezes it
  assign w_sig_shift = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h1021 : 16'h0000);

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      r_sig <= 16'hFFFF;
    end else if (start) begin
      r_sig <= 16'hFFFF;
    end else if (w_accept) begin
      r_sig <= w_sig_shift ^ 16'({s_vec, s_resp});
    end
  end

  assign sig = r_sig;
`endif

  assign ld_ready       = (r_state == ST_IDLE);
  assign s_ready        = (r_state == ST_CHECK);
  assign busy           = (r_state == ST_CHECK);
  assign done           = (r_state == ST_DONE);
  assign covered        = &r_seen;
  assign mm_cnt         = r_mm_cnt;
  assign acc_cnt        = r_acc_cnt;
  assign first_mm_valid = r_first_mm_valid;
  assign first_mm_vec   = r_first_mm_vec;

endmodule
`default_nettype wire

// File: tb/tb_trojan_resp_checker.sv
`default_nettype none
// Testbench for trojan_resp_checker: scenario tasks driven against a
// behavioural model of the golden table, coverage set and counters.
module tb_trojan_resp_checker;
  localparam int VEC_W = 8;
  localparam int CNT_W = 9;
  localparam int NV    = 256;
  localparam int CMAX  = 511;

  logic             CK = 1'b0;
  logic             reset, ld_valid, ld_bit, start, abort, s_valid, s_resp;
  logic [VEC_W-1:0] ld_addr, s_vec;
  logic             ld_ready, s_ready, busy, done, covered, first_mm_valid;
  logic [CNT_W-1:0] mm_cnt, acc_cnt;
  logic [VEC_W-1:0] first_mm_vec;
`ifdef TROJAN_RESP_MISR_EN
  logic [15:0]      sig;
`endif

  trojan_resp_checker #(.VEC_W(VEC_W), .CNT_W(CNT_W)) dut (
    .CK(CK), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_bit(ld_bit), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_vec(s_vec), .s_resp(s_resp),
    .busy(busy), .done(done), .covered(covered), .mm_cnt(mm_cnt),
    .acc_cnt(acc_cnt), .first_mm_valid(first_mm_valid),
    .first_mm_vec(first_mm_vec)
`ifdef TROJAN_RESP_MISR_EN
    , .sig(sig)
`endif
  );

  always #5 CK = ~CK;

  int total = 0;
  int bad   = 0;

  bit          m_gold[NV];
  bit          m_seen[NV];
  int          m_mm, m_acc, m_fmvec;
  bit          m_fmv;
  logic [15:0] m_sig;
  int          order_q[$];

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  function automatic int n_seen();
    int n = 0;
    foreach (m_seen[i]) n += int'(m_seen[i]);
    return n;
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input int v, input bit r);
    logic [15:0] t;
    t = s << 1;
    if (s[15]) t = t ^ 16'h1021;
    return t ^ ((16'(v) << 1) | 16'(r));
  endfunction

  task automatic model_clear();
    m_mm = 0; m_acc = 0; m_fmv = 0; m_fmvec = 0; m_sig = 16'hFFFF;
    foreach (m_seen[i]) m_seen[i] = 1'b0;
  endtask

  task automatic model_pair(input int v, input bit r);
    if (m_acc < CMAX) m_acc++;
    if (r != m_gold[v]) begin
      if (m_mm < CMAX) m_mm++;
      if (!m_fmv) begin m_fmv = 1'b1; m_fmvec = v; end
    end
    m_seen[v] = 1'b1;
    m_sig = misr_step(m_sig, v, r);
  endtask

  task automatic send(input int v, input bit r);
    s_valid = 1'b1; s_vec = VEC_W'(v); s_resp = r;
    tick();
    model_pair(v, r);
  endtask

  task automatic do_start();
    s_valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
  endtask

  task automatic do_abort();
    s_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // mode 0: parity table, mode 1: random table
  task automatic load_table(input int mode);
    if (done) begin
      ld_valid = 1'b1; ld_addr = '0; ld_bit = 1'b0;
      tick();
    end
    for (int i = 0; i < NV; i++) begin
      logic [7:0] a;
      a = 8'(i);
      ld_valid = 1'b1; ld_addr = a;
      ld_bit = (mode == 0) ? ^a : 1'($urandom_range(1));
      tick();
      m_gold[i] = ld_bit;
    end
    ld_valid = 1'b0;
  endtask

  task automatic make_order(input int skip);
    int j, t;
    order_q.delete();
    for (int i = 0; i < NV; i++) if (i != skip) order_q.push_back(i);
    for (int i = order_q.size() - 1; i > 0; i--) begin
      j = $urandom_range(i);
      t = order_q[i]; order_q[i] = order_q[j]; order_q[j] = t;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ld_valid = 0; ld_addr = 0; ld_bit = 0; start = 0; abort = 0;
    s_valid = 0; s_vec = 0; s_resp = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    foreach (m_gold[i]) m_gold[i] = 1'b0;
    model_clear();
    total++;
    if ({ld_ready, s_ready, busy, done, covered, first_mm_valid} !== 6'b100000) begin
      bad++; $display("FAIL reset_flags: got %b want 100000",
        {ld_ready, s_ready, busy, done, covered, first_mm_valid});
    end
    total++;
    if ({mm_cnt, acc_cnt, first_mm_vec} !== '0) begin
      bad++; $display("FAIL reset_values: mm=%0d acc=%0d fvec=%0d want all 0",
        mm_cnt, acc_cnt, first_mm_vec);
    end
  endtask

  task automatic test_full_match(output logic [15:0] sig_out);
    load_table(0);
    do_start();
    total++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || ld_ready !== 1'b0) begin
      bad++; $display("FAIL start_busy: busy=%b s_ready=%b ld_ready=%b want 1 1 0",
        busy, s_ready, ld_ready);
    end
    make_order(-1);
    for (int i = 0; i < NV; i++) begin
      send(order_q[i], m_gold[order_q[i]]);
      if (i == NV - 2) begin
        total++;
        if (done !== 1'b0 || covered !== 1'b0) begin
          bad++; $display("FAIL full_early_done: done=%b covered=%b want 0 0", done, covered);
        end
      end
    end
    s_valid = 1'b0;
    total++;
    if (done !== 1'b1 || covered !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL full_done: done=%b covered=%b busy=%b want 1 1 0", done, covered, busy);
    end
    total++;
    if (mm_cnt !== 9'd0 || acc_cnt !== 9'd256 || first_mm_valid !== 1'b0) begin
      bad++; $display("FAIL full_counts: mm=%0d acc=%0d fmv=%b want 0 256 0",
        mm_cnt, acc_cnt, first_mm_valid);
    end
`ifdef TROJAN_RESP_MISR_EN
    total++;
    if (sig !== m_sig) begin
      bad++; $display("FAIL full_sig: got %h want %h", sig, m_sig);
    end
    sig_out = sig;
`else
    sig_out = m_sig;
`endif
  endtask

  task automatic test_two_mismatch();
    do_start();
    for (int v = 0; v < NV; v++) send(v, m_gold[v] ^ (v == 8'h2A || v == 8'h91));
    s_valid = 1'b0;
    total++;
    if (mm_cnt !== 9'd2 || first_mm_valid !== 1'b1 || first_mm_vec !== 8'h2A) begin
      bad++; $display("FAIL two_mm: mm=%0d fmv=%b fvec=%h want 2 1 2a",
        mm_cnt, first_mm_valid, first_mm_vec);
    end
    total++;
    if (done !== 1'b1 || acc_cnt !== 9'd256) begin
      bad++; $display("FAIL two_mm_done: done=%b acc=%0d want 1 256", done, acc_cnt);
    end
  endtask

`ifdef TROJAN_RESP_MISR_EN
  task automatic test_misr(input logic [15:0] ref_sig);
    logic [15:0] s2;
    int          flip;
    do_start();
    for (int i = 0; i < NV; i++) send(order_q[i], m_gold[order_q[i]]);
    s_valid = 1'b0;
    s2 = sig;
    tick();
    total++;
    if (s2 !== ref_sig || sig !== s2) begin
      bad++; $display("FAIL misr_repeat: got %h (held %h) want %h", s2, sig, ref_sig);
    end
    flip = $urandom_range(NV - 1);
    do_start();
    for (int i = 0; i < NV; i++) send(order_q[i], m_gold[order_q[i]] ^ (order_q[i] == flip));
    s_valid = 1'b0;
    total++;
    if (sig === ref_sig || sig !== m_sig) begin
      bad++; $display("FAIL misr_flip: got %h want %h (clean %h)", sig, m_sig, ref_sig);
    end
  endtask
`endif

  task automatic test_abort();
    do_start();
    for (int v = 0; v < 100; v++) send(v, m_gold[v]);
    s_valid = 1'b0;
    tick();
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL abort_pre: busy=%b done=%b want 1 0", busy, done);
    end
    do_abort();
    total++;
    if (done !== 1'b1 || covered !== 1'b0 || acc_cnt !== 9'd100 || mm_cnt !== 9'd0) begin
      bad++; $display("FAIL abort: done=%b cov=%b acc=%0d mm=%0d want 1 0 100 0",
        done, covered, acc_cnt, mm_cnt);
    end
  endtask

  task automatic test_duplicates();
    do_start();
    repeat (3) send(5, m_gold[5]);
    make_order(5);
    for (int i = 0; i < NV - 1; i++) begin
      send(order_q[i], m_gold[order_q[i]]);
      if (i == NV - 3) begin
        total++;
        if (done !== 1'b0) begin
          bad++; $display("FAIL dup_early_done: done=%b want 0", done);
        end
      end
    end
    s_valid = 1'b0;
    total++;
    if (done !== 1'b1 || covered !== 1'b1 || acc_cnt !== 9'd258) begin
      bad++; $display("FAIL dup: done=%b cov=%b acc=%0d want 1 1 258", done, covered, acc_cnt);
    end
  endtask

  task automatic test_ld_in_done();
    total++;
    if (ld_ready !== 1'b0) begin
      bad++; $display("FAIL ld_ready_done: got %b want 0", ld_ready);
    end
    ld_valid = 1'b1; ld_addr = 8'h33; ld_bit = ~m_gold[8'h33];
    tick();
    ld_valid = 1'b0;
    total++;
    if (ld_ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL done_to_idle: ld_ready=%b done=%b want 1 0", ld_ready, done);
    end
    do_start();
    send(8'h33, m_gold[8'h33]);
    s_valid = 1'b0;
    total++;
    if (mm_cnt !== 9'd0) begin
      bad++; $display("FAIL ld_in_done_nowrite: mm=%0d want 0", mm_cnt);
    end
  endtask

  task automatic test_simultaneous();
    ld_valid = 1'b1; ld_addr = 8'h44; ld_bit = ~m_gold[8'h44];
    send(8'h10, m_gold[8'h10]);
    ld_valid = 1'b0;
    send(8'h44, m_gold[8'h44]);
    s_valid = 1'b0;
    total++;
    if (mm_cnt !== CNT_W'(m_mm) || acc_cnt !== CNT_W'(m_acc)) begin
      bad++; $display("FAIL ld_in_check: mm=%0d acc=%0d want %0d %0d", mm_cnt, acc_cnt, m_mm, m_acc);
    end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    model_clear();
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || acc_cnt !== 9'd0) begin
      bad++; $display("FAIL start_abort: busy=%b done=%b acc=%0d want 1 0 0", busy, done, acc_cnt);
    end
    abort = 1'b1;
    send(9, ~m_gold[9]);
    abort = 1'b0; s_valid = 1'b0;
    total++;
    if (done !== 1'b1 || acc_cnt !== 9'd1 || mm_cnt !== 9'd1 || first_mm_vec !== 8'd9) begin
      bad++; $display("FAIL abort_pair: done=%b acc=%0d mm=%0d fvec=%0d want 1 1 1 9",
        done, acc_cnt, mm_cnt, first_mm_vec);
    end
  endtask

  task automatic test_saturation();
    do_start();
    repeat (520) send(0, ~m_gold[0]);
    s_valid = 1'b0;
    total++;
    if (acc_cnt !== CNT_W'(m_acc) || mm_cnt !== CNT_W'(m_mm) || acc_cnt !== 9'd511) begin
      bad++; $display("FAIL saturate: acc=%0d mm=%0d want %0d %0d", acc_cnt, mm_cnt, m_acc, m_mm);
    end
    total++;
    if (first_mm_vec !== 8'd0 || done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL saturate_state: fvec=%0d done=%b busy=%b want 0 0 1",
        first_mm_vec, done, busy);
    end
    do_abort();
  endtask

  task automatic test_reset_mid();
    do_start();
    for (int v = 0; v < 50; v++) send(v, ~m_gold[v]);
    s_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({ld_ready, s_ready, busy, done, covered, first_mm_valid} !== 6'b100000 ||
        {mm_cnt, acc_cnt, first_mm_vec} !== '0) begin
      bad++; $display("FAIL reset_mid: flags=%b mm=%0d acc=%0d want 100000 0 0",
        {ld_ready, s_ready, busy, done, covered, first_mm_valid}, mm_cnt, acc_cnt);
    end
    foreach (m_gold[i]) m_gold[i] = 1'b0;
    model_clear();
    tick();
    reset = 1'b0;
    tick();
    load_table(0);
    do_start();
    for (int v = 0; v < NV; v++) send(v, ^(8'(v)));
    s_valid = 1'b0;
    total++;
    if (mm_cnt !== 9'd0 || done !== 1'b1 || acc_cnt !== 9'd256) begin
      bad++; $display("FAIL reload_run: mm=%0d done=%b acc=%0d want 0 1 256", mm_cnt, done, acc_cnt);
    end
  endtask

  task automatic test_random();
    int  cyc = 0;
    int  v;
    bit  r, cov;
    load_table(1);
    do_start();
    cov = 1'b0;
    while (!cov && cyc < 8000) begin
      if ($urandom_range(3) != 0) begin
        v = $urandom_range(NV - 1);
        r = m_gold[v] ^ ($urandom_range(15) == 0);
        send(v, r);
      end else begin
        s_valid = 1'b0;
        tick();
      end
      cyc++;
      cov = (n_seen() == NV);
      total++;
      if ({acc_cnt, mm_cnt, first_mm_valid, covered, done} !==
          {CNT_W'(m_acc), CNT_W'(m_mm), m_fmv, cov, cov} ||
          (m_fmv && first_mm_vec !== VEC_W'(m_fmvec))) begin
        bad++; $display("FAIL random_cyc%0d: acc=%0d mm=%0d fmv=%b fvec=%0d cov=%b done=%b want %0d %0d %b %0d %b %b",
          cyc, acc_cnt, mm_cnt, first_mm_valid, first_mm_vec, covered, done,
          m_acc, m_mm, m_fmv, m_fmvec, cov, cov);
      end
    end
    s_valid = 1'b0;
    total++;
    if (!cov) begin
      bad++; $display("FAIL random_timeout: seen=%0d want %0d", n_seen(), NV);
    end
  endtask

  initial begin
    logic [15:0] sig_ref;
    test_reset();
    test_full_match(sig_ref);
    test_two_mismatch();
`ifdef TROJAN_RESP_MISR_EN
    test_misr(sig_ref);
`endif
    test_abort();
    test_duplicates();
    test_ld_in_done();
    test_simultaneous();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trojan_resp_checker.md
Name: trojan_resp_checker

Overview:
- On-chip golden-response checker for the exhaustive-vector benchmark flow. It consumes the (vector, response) pairs that the stimulus side produces and compares each response against a golden truth table loaded beforehand.
- Reports mismatch count, the first mismatching vector, and whether every vector has been covered, replacing offline comparison of logged response text.

Parameters:
- VEC_W, 8, input vector width; the golden table holds 2**VEC_W bits.
- CNT_W, VEC_W+1, width of the mismatch and accepted-pair counters.

Ports:
- CK  in  1  clock, rising-edge active
- reset  in  1  asynchronous, active-high reset
- ld_valid  in  1  golden-table write strobe
- ld_ready  out  1  high only in IDLE
- ld_addr  in  VEC_W  golden entry index (vector value)
- ld_bit  in  1  golden response bit for ld_addr
- start  in  1  one-cycle pulse: clear results, enter CHECK
- abort  in  1  force CHECK to DONE
- s_valid  in  1  response pair valid
- s_ready  out  1  high only in CHECK
- s_vec  in  VEC_W  applied vector
- s_resp  in  1  DUT output bit for s_vec
- busy  out  1  high in CHECK
- done  out  1  high in DONE until the next start
- covered  out  1  all 2**VEC_W vectors seen at least once
- mm_cnt  out  CNT_W  mismatches, saturating at all-ones
- acc_cnt  out  CNT_W  accepted pairs, saturating
- first_mm_valid  out  1  at least one mismatch recorded
- first_mm_vec  out  VEC_W  vector of the first mismatch

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE.
  - Golden table, seen bitmap and all counters clear to 0.
  - All outputs read 0, except ld_ready, which is 1.
- FSM states: IDLE, CHECK, DONE.
- Transitions:
  - IDLE → CHECK on start.
  - CHECK → DONE on abort, or on the cycle the seen bitmap becomes all-ones.
  - DONE → CHECK on start.
  - DONE → IDLE on ld_valid.
  - start in CHECK restarts the run: results clear and the state stays CHECK.
- Load:
  - A write happens when ld_valid && ld_ready.
  - golden[ld_addr] <= ld_bit on that edge.
  - Writes in CHECK are ignored.
- Start:
  - On the start edge, clear mm_cnt, acc_cnt, the seen bitmap, first_mm_valid, first_mm_vec and done.
  - The golden table is preserved.
- Check:
  - A pair is accepted on a rising edge with s_valid && s_ready.
  - Mismatch means s_resp != golden[s_vec].
  - Results are registered and visible one cycle after acceptance.
  - acc_cnt increments on every accepted pair.
  - mm_cnt increments on every mismatch.
  - seen[s_vec] is set.
  - first_mm_vec and first_mm_valid are captured only when first_mm_valid is 0.
  - Duplicate vectors are re-checked and re-counted; coverage is unchanged by them.
- covered equals AND of the seen bitmap, combinational from registers.
- Completion:
  - The CHECK→DONE transition happens on the same edge that accepts the final uncovered vector; that pair's result is included.
  - done and covered are both high the following cycle.
- Saturation: both counters hold at 2**CNT_W-1 and never wrap.
- Simultaneous events:
  - start and abort in the same cycle: start wins.
  - abort and an accepted pair in the same cycle: the pair is counted, then the state goes to DONE.
- Reset mid-CHECK: immediate return to IDLE. The golden table is lost and must be reloaded.
- ld_valid in DONE: moves to IDLE without writing. The write is accepted on the next cycle.

Optional Feature:
- Macro: TROJAN_RESP_MISR_EN.
- When defined:
  - Adds a 16-bit output sig.
  - sig is a MISR with polynomial x^16+x^12+x^5+1 and seed 16'hFFFF, set at reset and on start.
  - On each accepted pair, sig <= shift(sig) XOR {s_vec, s_resp} zero-extended to 16 bits.
  - sig is frozen in DONE.
- When undefined: no sig port and no MISR logic; all other behaviour is identical.

Test Plan:
- Load golden = parity(vec) for all 256 entries, start, then stream all 256 vectors with matching responses → done=1, covered=1, mm_cnt=0, acc_cnt=256, first_mm_valid=0.
- Same as above, but flip responses for vec 8'h2A and 8'h91 (in order) → mm_cnt=2, first_mm_vec=8'h2A, first_mm_valid=1.
- Stream only vectors 0..99, then abort → done=1, covered=0, acc_cnt=100.
- Send vec 8'h05 three times, then all others → acc_cnt=258, covered=1, done asserted on the cycle after the 256th unique vector.
- Assert reset mid-CHECK after 50 pairs → all outputs 0 and ld_ready=1 asynchronously. Next, reload, start and stream all vectors → mm_cnt=0.
- With TROJAN_RESP_MISR_EN, run the first scenario twice → identical sig both runs. Then flip one response → sig differs.
